// File: rtl/id_ex_operand_stage.sv
// ID/EX operand stage: latches decoded operands, resolves hazards and presents ALU operands.
// Define ALU_FWD_EN for EX/MEM and MEM/WB forwarding; otherwise RAW dependences stall instead.
module id_ex_operand_stage #(
  parameter int n  = 32,
  parameter int RA = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          id_valid,
  output logic          id_ready,
  input  logic [n-1:0]  id_rs1_data,
  input  logic [n-1:0]  id_rs2_data,
  input  logic [n-1:0]  id_imm,
  input  logic [RA-1:0] id_rs1_addr,
  input  logic [RA-1:0] id_rs2_addr,
  input  logic [RA-1:0] id_rd_addr,
  input  logic          id_alu_src,
  input  logic [3:0]    id_alu_ctrl,
  input  logic          id_unsigned,
  input  logic          id_reg_write,
  input  logic          id_mem_read,
  input  logic          stall,
  input  logic          flush,
  input  logic [RA-1:0] exmem_rd_addr,
  input  logic          exmem_reg_write,
  input  logic [n-1:0]  exmem_result,
  input  logic [RA-1:0] memwb_rd_addr,
  input  logic          memwb_reg_write,
  input  logic [n-1:0]  memwb_result,
  output logic          ex_valid,
  output logic [n-1:0]  alu_rs1,
  output logic [n-1:0]  alu_rs2,
  output logic [3:0]    alu_ctrl,
  output logic          unsigned_signal,
  output logic [n-1:0]  ex_store_data,
  output logic [RA-1:0] ex_rd_addr,
  output logic          ex_reg_write,
  output logic          ex_mem_read,
  output logic          hazard_stall
);

  logic [n-1:0] rs1_data_q;
  logic [n-1:0] rs2_data_q;
  logic [n-1:0] imm_q;
  logic         alu_src_q;
  logic         load_use;
  logic [n-1:0] rs1_fwd;
  logic [n-1:0] rs2_fwd;

  assign load_use = id_valid && ex_valid && ex_mem_read && (ex_rd_addr != '0) &&
                    ((ex_rd_addr == id_rs1_addr) || (ex_rd_addr == id_rs2_addr));

`ifdef ALU_FWD_EN
  logic [RA-1:0] rs1_addr_q;
  logic [RA-1:0] rs2_addr_q;

  assign hazard_stall = load_use;

  // EX/MEM is younger than MEM/WB, so it has priority when both match.
  always_comb begin
    rs1_fwd = rs1_data_q;
    if (exmem_reg_write && (exmem_rd_addr != '0) && (exmem_rd_addr == rs1_addr_q))
      rs1_fwd = exmem_result;
    else if (memwb_reg_write && (memwb_rd_addr != '0) && (memwb_rd_addr == rs1_addr_q))
      rs1_fwd = memwb_result;
  end

  always_comb begin
    rs2_fwd = rs2_data_q;
    if (exmem_reg_write && (exmem_rd_addr != '0) && (exmem_rd_addr == rs2_addr_q))
      rs2_fwd = exmem_result;
    else if (memwb_reg_write && (memwb_rd_addr != '0) && (memwb_rd_addr == rs2_addr_q))
      rs2_fwd = memwb_result;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rs1_addr_q <= '0;
      rs2_addr_q <= '0;
    end else if (!flush && !stall && !hazard_stall) begin
      rs1_addr_q <= id_rs1_addr;
      rs2_addr_q <= id_rs2_addr;
    end
  end
`else
  logic raw_rs1;
  logic raw_rs2;
  logic unused_fwd_inputs;

  // Without forwarding, any producer still in EX or EX/MEM must retire first;
  // the register file is write-before-read, so MEM/WB is already visible.
  assign raw_rs1 = (id_rs1_addr != '0) &&
                   ((ex_valid && ex_reg_write && (ex_rd_addr == id_rs1_addr)) ||
                    (exmem_reg_write && (exmem_rd_addr == id_rs1_addr)));
  assign raw_rs2 = (id_rs2_addr != '0) &&
                   ((ex_valid && ex_reg_write && (ex_rd_addr == id_rs2_addr)) ||
                    (exmem_reg_write && (exmem_rd_addr == id_rs2_addr)));

  assign hazard_stall = load_use || (id_valid && (raw_rs1 || raw_rs2));

  assign rs1_fwd = rs1_data_q;
  assign rs2_fwd = rs2_data_q;

  assign unused_fwd_inputs = ^{exmem_result, memwb_rd_addr, memwb_reg_write, memwb_result};
`endif

  assign id_ready      = (!stall && !hazard_stall) || flush;
  assign alu_rs1       = rs1_fwd;
  assign alu_rs2       = alu_src_q ? imm_q : rs2_fwd;
  assign ex_store_data = rs2_fwd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid        <= 1'b0;
      ex_reg_write    <= 1'b0;
      ex_mem_read     <= 1'b0;
      ex_rd_addr      <= '0;
      alu_ctrl        <= 4'b0000;
      unsigned_signal <= 1'b0;
      alu_src_q       <= 1'b0;
      rs1_data_q      <= '0;
      rs2_data_q      <= '0;
      imm_q           <= '0;
    end else if (flush) begin
      ex_valid     <= 1'b0;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
    end else if (!stall) begin
      if (hazard_stall) begin
        ex_valid     <= 1'b0;
        ex_reg_write <= 1'b0;
        ex_mem_read  <= 1'b0;
      end else begin
        ex_valid        <= id_valid;
        ex_reg_write    <= id_reg_write & id_valid;
        ex_mem_read     <= id_mem_read & id_valid;
        ex_rd_addr      <= id_rd_addr;
        alu_ctrl        <= id_alu_ctrl;
        unsigned_signal <= id_unsigned;
        alu_src_q       <= id_alu_src;
        rs1_data_q      <= id_rs1_data;
        rs2_data_q      <= id_rs2_data;
        imm_q           <= id_imm;
      end
    end
  end

endmodule

// File: doc/id_ex_operand_stage.md
Name: id_ex_operand_stage

Overview:
- ID/EX pipeline register directly upstream of the ALU in the 5-stage RV32I core.
- Captures decoded operands and control from ID, resolves data hazards via EX/MEM and MEM/WB forwarding, detects load-use hazards, and presents final operands (`alu_rs1`, `alu_rs2`, `alu_ctrl`, `unsigned_signal`) to the ALU.
- Supports downstream stall and branch flush.

Parameters:
- n, 32, datapath width
- RA, 5, register address width

Ports:
- clk  in  1  core clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  ID holds a valid instruction
- id_ready  out  1  stage accepts ID instruction this cycle
- id_rs1_data  in  n  register-file read port 1
- id_rs2_data  in  n  register-file read port 2
- id_imm  in  n  sign-extended immediate
- id_rs1_addr  in  RA  source 1 index
- id_rs2_addr  in  RA  source 2 index
- id_rd_addr  in  RA  destination index
- id_alu_src  in  1  1: operand B = immediate
- id_alu_ctrl  in  4  ALU op code
- id_unsigned  in  1  unsigned qualifier
- id_reg_write  in  1  instruction writes rd
- id_mem_read  in  1  instruction is a load
- stall  in  1  downstream hold request
- flush  in  1  squash (taken branch/jump)
- exmem_rd_addr  in  RA  EX/MEM destination
- exmem_reg_write  in  1  EX/MEM writes rd
- exmem_result  in  n  EX/MEM ALU result
- memwb_rd_addr  in  RA  MEM/WB destination
- memwb_reg_write  in  1  MEM/WB writes rd
- memwb_result  in  n  MEM/WB writeback value
- ex_valid  out  1  EX holds a valid instruction
- alu_rs1  out  n  ALU operand A (forwarded)
- alu_rs2  out  n  ALU operand B (immediate or forwarded rs2)
- alu_ctrl  out  4  registered op code
- unsigned_signal  out  1  registered qualifier
- ex_store_data  out  n  forwarded rs2, for stores
- ex_rd_addr  out  RA  registered rd
- ex_reg_write  out  1  registered; 0 when bubble
- ex_mem_read  out  1  registered; 0 when bubble
- hazard_stall  out  1  hazard detected; ID must hold

Behaviour:
Reset:
- rst_n low clears all registers asynchronously, independent of clk.
- Outputs read: `ex_valid`=0, `ex_reg_write`=0, `ex_mem_read`=0, `alu_ctrl`=4'b0000, `unsigned_signal`=0, `ex_rd_addr`=0.
- Data registers clear to 0; `alu_rs1`/`alu_rs2` follow the forwarding rules applied to zeroed state.

Register update (rising edge), priority order:
1. flush=1: `ex_valid`, `ex_reg_write`, `ex_mem_read` <= 0.
2. stall=1: all registers hold.
3. hazard_stall=1: insert bubble (same clears as flush); other fields hold.
4. Otherwise: capture all `id_*` fields; `ex_valid` <= id_valid; `ex_reg_write`/`ex_mem_read` <= id_* AND id_valid.

Handshake:
- `id_ready` = !stall && !hazard_stall, OR flush.
- During flush the ID instruction is also considered squashed; ID must not retain it.

Load-use hazard:
- `hazard_stall` = id_valid && ex_valid && ex_mem_read && ex_rd_addr!=0 && (ex_rd_addr==id_rs1_addr || ex_rd_addr==id_rs2_addr).
- Combinational; exactly one bubble per load-use pair.

Forwarding (combinational, from registered rs addresses):
- Source X: if exmem_reg_write && exmem_rd_addr!=0 && match → exmem_result.
- Else if memwb_reg_write && memwb_rd_addr!=0 && match → memwb_result.
- Else registered register-file data.
- EX/MEM wins when both match. x0 never forwarded.

Operand selection:
- `alu_rs1` = fwd(rs1).
- `alu_rs2` = registered imm if alu_src, else fwd(rs2).
- `ex_store_data` = fwd(rs2) always.

Latency:
- One cycle ID→EX; operands valid in the same cycle as `ex_valid`.

Simultaneous events:
- flush beats stall and hazard_stall.
- stall together with hazard_stall: hold, no bubble.
- Reset mid-stall: clears everything; first post-reset edge is a normal capture.

Optional Feature:
Macro ALU_FWD_EN.
- Defined: forwarding as above.
- Undefined: no forwarding muxes; operands come straight from registered data.
  - `hazard_stall` also asserts when id_valid and a nonzero source matches ex_rd_addr (ex_valid && ex_reg_write) or exmem_rd_addr (exmem_reg_write).
  - Register file is write-before-read, so MEM/WB needs no stall.

Test Plan:
- Reset: rst_n=0 mid-cycle with ex_valid=1 → ex_valid=0, ex_reg_write=0, alu_ctrl=0 immediately, before next clk edge.
- EX/MEM forwarding: add x5 in EX/MEM, exmem_result=0x0000_0010, next instr rs1=x5, id_rs1_data=0 → alu_rs1=0x10. Same rd in MEM/WB with 0x20 → still 0x10.
- x0 guard: exmem_rd_addr=0, exmem_reg_write=1, result 0xFFFF_FFFF, rs1=x0, rs1_data=0 → alu_rs1=0.
- Load-use: lw x7 in EX, ID instr rs2=x7 → hazard_stall=1, id_ready=0 for exactly one cycle; next cycle ex_valid=0 bubble; following cycle instruction captured.
- Immediate select: alu_src=1, imm=0xFFFF_F800, rs2 forwarded 0x5 → alu_rs2=0xFFFF_F800, ex_store_data=0x5.
- Flush with stall: flush=1, stall=1 → next cycle ex_valid=0, ex_reg_write=0, id_ready=1.
